// File: rtl/shift_reg_ctrl_pkg.sv
// Shared encodings for the shift-register command sequencer and the 3-bit
// universal shift register it drives.
package shift_reg_ctrl_pkg;

    // Mode select {s1,s0} understood by the shift register
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Command op codes share the mode encoding on purpose
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [1:0] op_to_mode(input logic [1:0] op);
        logic [1:0] mode;
        case (op)
            OP_SHR:  mode = MODE_SHR;
            OP_SHL:  mode = MODE_SHL;
            OP_LOAD: mode = MODE_LOAD;
            default: mode = MODE_HOLD;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/shift_reg_ctrl.sv
// Command sequencer for the 3-bit universal shift register: one command per
// valid/ready handshake, registered mode/data/fill outputs, one-cycle done pulse.
module shift_reg_ctrl
    import shift_reg_ctrl_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] I_par,
    output logic             MSB_in,
    output logic             LSB_in,
    output logic             busy,
    output logic             done,
    output state_e           dbg_state
);

    // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE and outside reset, and cmd_* is ignored otherwise.
    logic             cmd_accept;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] ipar_q, ipar_d;
    logic             msb_q, msb_d;
    logic             lsb_q, lsb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    assign cmd_ready  = (state_q == ST_IDLE) && Clear_b;
    assign cmd_accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        ipar_d  = ipar_q;
        msb_d   = msb_q;
        lsb_d   = lsb_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    ipar_d = cmd_data;
                    msb_d  = (cmd_op == OP_SHR) ? cmd_fill : 1'b0;
                    lsb_d  = (cmd_op == OP_SHL) ? cmd_fill : 1'b0;
                    rem_d  = cmd_cnt;
                    dir_d  = op_to_mode(cmd_op);
                    if (cmd_op == OP_LOAD)
                        state_d = ST_LOAD;
                    else if ((cmd_op == OP_SHR || cmd_op == OP_SHL) && cmd_cnt != '0)
                        state_d = ST_SHIFT;
                    else
                        state_d = ST_DONE;
                end
            end
            ST_LOAD:  state_d = ST_DONE;
            ST_SHIFT: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1))
                    state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered
        case (state_d)
            ST_LOAD:  mode_d = MODE_LOAD;
            ST_SHIFT: mode_d = dir_d;
            default:  mode_d = MODE_HOLD;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (!Clear_b) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            dir_q   <= MODE_HOLD;
            mode_q  <= MODE_HOLD;
            ipar_q  <= '0;
            msb_q   <= 1'b0;
            lsb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            ipar_q  <= ipar_d;
            msb_q   <= msb_d;
            lsb_q   <= lsb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s1        = mode_q[1];
    assign s0        = mode_q[0];
    assign I_par     = ipar_q;
    assign MSB_in    = msb_q;
    assign LSB_in    = lsb_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
- Command sequencer directly upstream of the 3-bit universal shift register.
- Accepts one command per valid/ready handshake: hold, shift right N, shift left N, or parallel load.
- Drives the register's mode select (s1,s0), parallel data (I_par) and serial fill bits (MSB_in, LSB_in) for exactly the required number of clock cycles.
- Pulses done when the operation is complete.

Parameters:
- WIDTH, 3, width of the parallel data path (matches the shift register).
- CNT_W, 3, width of the shift-count field (max N = 2^CNT_W-1).

Ports:
- CLK  input  1  system clock, rising edge.
- Clear_b  input  1  synchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  00 hold/NOP, 01 shift right, 10 shift left, 11 parallel load.
- cmd_cnt  input  CNT_W  number of shift cycles (ignored for NOP/load).
- cmd_data  input  WIDTH  parallel load value.
- cmd_fill  input  1  serial fill bit for shifts.
- s1  output  1  mode select to shift register, high bit.
- s0  output  1  mode select to shift register, low bit.
- I_par  output  WIDTH  parallel data to shift register.
- MSB_in  output  1  serial input for right shift.
- LSB_in  output  1  serial input for left shift.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset and clocking:
  - Clear_b is sampled on the rising CLK edge only.
  - On reset: state=IDLE; s1=s0=0; I_par=0; MSB_in=LSB_in=0; busy=0; done=0.
  - cmd_ready is 0 while Clear_b=0.
  - All outputs except cmd_ready are registered.
- Mode encoding (s1,s0): 00 hold, 01 shift right (MSB_in enters the top bit), 10 shift left (LSB_in enters bit 0), 11 parallel load.
- States: IDLE, LOAD, SHIFT, DONE.
- cmd_ready = (state==IDLE) && Clear_b. Accept = cmd_valid && cmd_ready at a rising edge.
- On accept:
  - I_par <= cmd_data for every op.
  - Shift right: MSB_in <= cmd_fill, LSB_in <= 0.
  - Shift left: LSB_in <= cmd_fill, MSB_in <= 0.
  - Other ops: both fill bits <= 0.
  - remaining <= cmd_cnt.
- Transitions on accept:
  - op=11 -> LOAD.
  - op=01/10 with cnt>0 -> SHIFT.
  - op=00, or shift with cnt=0 -> DONE.
- LOAD:
  - {s1,s0}=11 for exactly one cycle, so the register loads at the next edge.
  - Then -> DONE.
- SHIFT:
  - {s1,s0}=01 or 10 held for exactly cnt consecutive cycles, so the register shifts cnt times.
  - remaining decrements each edge; the last shift cycle is remaining==1, then -> DONE.
- DONE:
  - {s1,s0}=00, done=1 for one cycle, then -> IDLE.
  - done is never high in any other state.
- busy=1 in LOAD, SHIFT and DONE; busy=0 in IDLE.
- Timing: accept at edge E0 -> mode active during cycles following E0..E(N-1) -> done high in the cycle after edge EN (N=1 for load, N=0 for NOP/cnt=0). Minimum command-to-command spacing is N+2 edges.
- {s1,s0}=00 whenever in IDLE or DONE.
- I_par and the fill bits hold their value until the next accept; they are not cleared in IDLE.
- cmd_valid or cmd_* changes while busy are ignored; latched values are used.
- Reset mid-operation: the op is aborted at the next edge, outputs go to reset values, and no done pulse is produced.
- cmd_cnt at maximum (7 for CNT_W=3): exactly 7 shift cycles; no wrap.

Decomposition:
- Shared header/package holds:
  - Mode localparams MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11, used by both this block and the shift register.
  - Command op codes with the same encoding.
  - State encoding localparams.
- No sub-module is needed; the count-down counter stays inline.
- The bench instantiates shift_reg_ctrl driving shift_Register_3bit.

Test Plan:
- Reset: Clear_b=0 for 2 edges with cmd_valid=1 -> cmd_ready=0, s1s0=00, I_par=000, done=0; after release cmd_ready=1.
- Load: cmd_op=11, cmd_data=101 -> s1s0=11 for exactly 1 cycle, then done pulse; register A_par=101.
- Shift right: from 101, op=01, cnt=2, fill=1 -> s1s0=01 for 2 cycles; A_par 101->110->111; done 1 cycle later; MSB_in=1, LSB_in=0.
- Shift left: from 111, op=10, cnt=1, fill=0 -> A_par=110; s1s0=10 for 1 cycle.
- Boundary:
  - op=01, cnt=0 -> no shift cycle; done in the cycle after accept; A_par unchanged.
  - cnt=7 -> exactly 7 shift cycles counted.
- Abort: Clear_b=0 during the 3rd cycle of a cnt=5 shift -> s1s0=00 next edge, no done, cmd_ready=1 one edge after release.
